// File: rtl/mmio_timer_if.sv
// mmio_timer_if: data-memory bus between the CPU load/store path and the timer.
// The CPU drives address/data_write/mem_wr; the timer answers with data_read/hit.
interface mmio_timer_if;
    logic [12:0] address;
    logic [63:0] data_write;
    logic        mem_wr;
    logic [63:0] data_read;
    logic        hit;

    modport master (
        output address, data_write, mem_wr,
        input  data_read, hit
    );

    modport slave (
        input  address, data_write, mem_wr,
        output data_read, hit
    );
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: prescaled 64-bit timer with compare/irq on the data-memory bus.
// Optional input capture is built only when MMIO_TIMER_CAPTURE_EN is defined.
module mmio_timer #(
    parameter logic [12:0] BASE_ADDR  = 13'h1F00,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    mmio_timer_if.slave bus,
    input  logic        capture_in,
    output logic        irq
);
    typedef enum logic [1:0] {
        IDLE,
        COUNTING,
        HALTED
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [63:0]           count_q, count_d;
    logic [63:0]           compare_q, compare_d;
    logic [63:0]           capture_q, capture_d;
    logic                  match_q, match_d;
    logic                  ovf_q, ovf_d;
    logic                  cap_q, cap_d;
    logic [7:0]            match_cnt_q, match_cnt_d;

    logic [12:0] offset;
    logic [9:0]  idx;
    logic        sel;
    logic        wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
    logic        tick, match_set, ovf_set, cap_edge;
    logic [63:0] dw;

    assign dw       = bus.data_write;
    assign offset   = bus.address - BASE_ADDR;
    assign idx      = 10'(offset >> 3);
    assign sel      = (idx <= 10'd5);
    assign bus.hit  = sel;
    assign wr_ctrl   = bus.mem_wr && sel && (idx == 10'd0);
    assign wr_presc  = bus.mem_wr && sel && (idx == 10'd1);
    assign wr_count  = bus.mem_wr && sel && (idx == 10'd2);
    assign wr_cmp    = bus.mem_wr && sel && (idx == 10'd3);
    assign wr_status = bus.mem_wr && sel && (idx == 10'd4);
    assign tick = (state_q == COUNTING) && (presc_cnt_q == presc_q);
    assign irq  = match_q & ctrl_q[2];

`ifdef MMIO_TIMER_CAPTURE_EN
    logic sync1_q, sync2_q, prev_q;

    // Two-flop synchronizer on the async pin plus one history stage for edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= capture_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign cap_edge = sync2_q & ~prev_q;
`else
    logic unused_capture_in;
    assign unused_capture_in = capture_in;
    assign cap_edge = 1'b0;
`endif

    // Next-state: tick effects first, then software writes override them
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;
        count_d     = count_q;
        compare_d   = compare_q;
        capture_d   = capture_q;
        match_set   = 1'b0;
        ovf_set     = 1'b0;
        // A disabling CTRL write freezes COUNT even if a tick lands with it
        if (tick && !(wr_ctrl && !dw[0])) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                if (ctrl_q[1]) begin
                    count_d = '0;
                end else begin
                    state_d = HALTED;
                end
            end else begin
                count_d = count_q + 64'd1;
                ovf_set = &count_q;
            end
        end
        if (tick) begin
            presc_cnt_d = '0;
        end else if (state_q == COUNTING) begin
            presc_cnt_d = presc_cnt_q + PRESCALE_W'(1);
        end
        if (wr_ctrl) begin
            ctrl_d  = dw[2:0];
            state_d = dw[0] ? COUNTING : IDLE;
            if (state_q != COUNTING || !dw[0]) begin
                presc_cnt_d = '0;
            end
        end
        if (wr_presc) presc_d = dw[PRESCALE_W-1:0];
        if (wr_count) count_d = dw;
        if (wr_cmp) compare_d = dw;
        if (cap_edge) capture_d = count_q;
        match_d = (match_q & ~(wr_status & dw[0])) | match_set;
        ovf_d   = (ovf_q & ~(wr_status & dw[1])) | ovf_set;
        cap_d   = (cap_q & ~(wr_status & dw[2])) | cap_edge;
        match_cnt_d = wr_status ? 8'd0 : match_cnt_q;
        if (match_set && match_cnt_d != 8'hFF) begin
            match_cnt_d = match_cnt_d + 8'd1;
        end
    end

    // Register all timer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            count_q     <= '0;
            compare_q   <= '0;
            capture_q   <= '0;
            match_q     <= 1'b0;
            ovf_q       <= 1'b0;
            cap_q       <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            capture_q   <= capture_d;
            match_q     <= match_d;
            ovf_q       <= ovf_d;
            cap_q       <= cap_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    // Combinational read mux; zero outside the window or at unmapped slots
    always_comb begin
        bus.data_read = '0;
        if (sel) begin
            case (idx)
                10'd0:   bus.data_read = {61'd0, ctrl_q};
                10'd1:   bus.data_read = {{(64-PRESCALE_W){1'b0}}, presc_q};
                10'd2:   bus.data_read = count_q;
                10'd3:   bus.data_read = compare_q;
                10'd4:   bus.data_read = {48'd0, match_cnt_q, 5'd0,
                                          cap_q, ovf_q, match_q};
                10'd5:   bus.data_read = capture_q;
                default: bus.data_read = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: randomized + directed stimulus, scoreboard against a
// cycle-level behavioural model of the timer register file.
module tb_mmio_timer;
    localparam logic [12:0] BASE = 13'h1F00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic capture_in = 1'b0;
    logic irq;
    logic cin_v = 1'b0;

    mmio_timer_if bus();

    mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .capture_in(capture_in),
        .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] addr;
        logic [63:0] data;
        logic        hit;
        logic        irq;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;

    // Reference model state
    logic [2:0]  m_ctrl;
    logic [15:0] m_presc, m_pc;
    logic [63:0] m_count, m_compare, m_capture;
    bit          m_run, m_match, m_ovf, m_cap;
    int          m_mcnt;
    bit          s1, s2, s3;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_ctrl = 0; m_presc = 0; m_pc = 0;
        m_count = 0; m_compare = 0; m_capture = 0;
        m_run = 0; m_match = 0; m_ovf = 0; m_cap = 0; m_mcnt = 0;
        s1 = 0; s2 = 0; s3 = 0;
    endtask

    function automatic logic m_hit(input logic [12:0] a);
        logic [12:0] off;
        off = a - BASE;
        return off <= 13'h2F;
    endfunction

    function automatic logic [63:0] m_read(input logic [12:0] a);
        logic [12:0] off;
        off = a - BASE;
        if (off > 13'h2F) return 64'd0;
        case (int'(off) / 8)
            0: return {61'd0, m_ctrl};
            1: return {48'd0, m_presc};
            2: return m_count;
            3: return m_compare;
            4: return {48'd0, 8'(m_mcnt), 5'd0, m_cap, m_ovf, m_match};
            default: return m_capture;
        endcase
    endfunction

    // Advance the model by one clock edge given this cycle's bus inputs
    task automatic m_step(input logic [12:0] a, input logic [63:0] d,
                          input logic w, input logic cin);
        logic [12:0] off;
        logic [63:0] n_count;
        int r;
        bit tick, stop, mset, oset, cedge, run0;
        off = a - BASE;
        r = (w && off <= 13'h2F) ? int'(off) / 8 : -1;
        run0 = m_run;
        tick = m_run && (m_pc == m_presc);
        stop = (r == 0) && !d[0];
        mset = 0; oset = 0; cedge = 0;
        n_count = m_count;
`ifdef MMIO_TIMER_CAPTURE_EN
        cedge = s2 && !s3;
        s3 = s2; s2 = s1; s1 = cin;
`else
        if (cin) cedge = 0;
`endif
        if (cedge) m_capture = m_count;
        if (tick && !stop) begin
            if (m_count == m_compare) begin
                mset = 1;
                if (m_ctrl[1]) n_count = 0;
                else m_run = 0;
            end else begin
                n_count = m_count + 1;
                oset = (m_count == 64'hFFFF_FFFF_FFFF_FFFF);
            end
        end
        if (tick) m_pc = 0;
        else if (run0) m_pc = m_pc + 1;
        if (r == 0) begin
            m_ctrl = d[2:0];
            if (!(run0 && d[0])) m_pc = 0;
            m_run = d[0];
        end
        if (r == 1) m_presc = d[15:0];
        if (r == 2) n_count = d;
        if (r == 3) m_compare = d;
        if (r == 4) begin
            if (d[0]) m_match = 0;
            if (d[1]) m_ovf = 0;
            if (d[2]) m_cap = 0;
            m_mcnt = 0;
        end
        if (mset) begin
            m_match = 1;
            if (m_mcnt < 255) m_mcnt++;
        end
        if (oset) m_ovf = 1;
        if (cedge) m_cap = 1;
        m_count = n_count;
    endtask

    // One bus cycle: drive, queue the expected response, step the model
    task automatic cyc(input logic [12:0] a, input logic [63:0] d,
                       input logic w);
        exp_t e;
        @(posedge clk);
        #1;
        bus.address = a;
        bus.data_write = d;
        bus.mem_wr = w;
        capture_in = cin_v;
        e.addr = a;
        e.data = m_read(a);
        e.hit = m_hit(a);
        e.irq = m_match & m_ctrl[2];
        sbq.push_back(e);
        m_step(a, d, w, cin_v);
    endtask

    task automatic wr(input int r, input logic [63:0] d);
        cyc(13'(BASE + 13'(r * 8)), d, 1'b1);
    endtask

    task automatic rd(input int r, input int n);
        repeat (n) cyc(13'(BASE + 13'(r * 8)), 64'd0, 1'b0);
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #1;
        bus.mem_wr = 1'b0;
        bus.address = BASE + 13'h10;
        cin_v = 1'b0;
        capture_in = 1'b0;
        rst_n = 1'b0;
        #1 chk("rst_count", bus.data_read, 64'd0);
        chk("rst_irq", {63'd0, irq}, 64'd0);
        bus.address = BASE + 13'h20;
        #1 chk("rst_status", bus.data_read, 64'd0);
        bus.address = BASE;
        #1 chk("rst_ctrl", bus.data_read, 64'd0);
        bus.address = BASE + 13'h30;
        #1 chk("rst_unmapped", bus.data_read, 64'd0);
        chk("rst_hit", {63'd0, bus.hit}, 64'd0);
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare each presented bus response against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk($sformatf("rd@%h", e.addr), bus.data_read, e.data);
                chk($sformatf("hit@%h", e.addr), {63'd0, bus.hit},
                    {63'd0, e.hit});
                chk("irq", {63'd0, irq}, {63'd0, e.irq});
            end
        end
    end

    initial begin
        bus.address = 13'd0;
        bus.data_write = 64'd0;
        bus.mem_wr = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // compare run to halt with irq
        wr(1, 0); wr(3, 5); wr(0, 5);
        rd(2, 8); rd(4, 2);
        wr(4, 1); rd(4, 2);

        // mid-count asynchronous reset
        wr(0, 0); wr(2, 64'h55); wr(3, 64'h57); wr(0, 5);
        rd(2, 5);
        async_reset_check();

        // auto-reload with prescaler, match_cnt and its clear
        wr(4, 7); wr(2, 0); wr(1, 3); wr(3, 2); wr(0, 3);
        rd(2, 50); rd(4, 1);
        wr(4, 0); rd(4, 2);

        // overflow wrap and W1C colliding with a new overflow
        wr(0, 0); wr(1, 0); wr(3, 64'h10); wr(4, 7);
        wr(2, 64'hFFFF_FFFF_FFFF_FFFF); wr(0, 1);
        rd(2, 1); rd(4, 2);
        wr(2, 64'hFFFF_FFFF_FFFF_FFFF); wr(4, 2); rd(4, 2);

        // COUNT store beats a tick; disable freezes COUNT
        wr(0, 0); wr(3, 64'hFFFF); wr(2, 0); wr(0, 1);
        rd(2, 3); wr(2, 64'h100); rd(2, 2);
        wr(0, 0); rd(2, 10);

        // input capture
        wr(1, 7); wr(2, 64'h20); wr(4, 7); wr(0, 1);
        cin_v = 1'b1; rd(5, 2);
        cin_v = 1'b0; rd(5, 6); rd(4, 2);

        // randomized traffic
        repeat (600) begin
            int k, r;
            logic [63:0] d;
            if ($urandom_range(0, 15) == 0) cin_v = ~cin_v;
            k = $urandom_range(0, 9);
            r = $urandom_range(0, 7);
            if (k <= 4) begin
                if (k == 0)
                    cyc(13'($urandom), 64'd0, 1'b0);
                else
                    cyc(13'(BASE + 13'(r * 8 + $urandom_range(0, 7))),
                        64'd0, 1'b0);
            end else begin
                d = {32'($urandom), 32'($urandom)};
                case (r)
                    0: d = 64'($urandom_range(0, 7));
                    1: d = 64'($urandom_range(0, 3));
                    2: d = ($urandom_range(0, 3) == 0)
                           ? 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 4))
                           : 64'($urandom_range(0, 30));
                    3: d = 64'($urandom_range(0, 30));
                    default: ;
                endcase
                if (k == 9 && r == 0)
                    cyc(13'($urandom), d, 1'b1);
                else
                    wr(r, d);
            end
        end

        begin
            int waited;
            waited = 0;
            while (sbq.size() > 0 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            total++;
            if (sbq.size() > 0) begin
                bad++;
                $display("FAIL drain: got %0d pending want 0", sbq.size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
